// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_pkg
// Description : Shared constants for the sequential binary-to-BCD converter
//               and the seven-segment display path it feeds: digit count,
//               largest displayable value, overflow glyph and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_seq_pkg;

    // Number of decimal digits on the display; must match the driver.
    localparam int c_bcd_digits = 8;
    localparam int c_bcd_w      = 4 * c_bcd_digits;

    // Largest value that fits in c_bcd_digits decimal digits.
    localparam int c_max_dec    = 99999999;

    // Byte shown on every digit pair when the value does not fit ("FF").
    localparam logic [7:0] c_ovf_pattern = 8'hFF;

    // Converter FSM encoding.
    localparam int          c_state_w = 2;
    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_conv = 2'd1;
    localparam logic [1:0]  c_st_done = 2'd2;

endpackage : bin2bcd_seq_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble digit correction. Adds 3 to a BCD nibble that
//               is 5 or more so the following left shift carries correctly
//               into the next decimal digit. Purely combinational.
// Ports       : i_digit - 4-bit BCD digit before correction
//               o_digit - 4-bit corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Wraps modulo 16 by design; only reached for digits 5..15.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter (shift-add-3, one input
//               bit per clock). Produces 8 packed BCD digits for the
//               seven-segment driver; values above MAX_DEC show "FFFFFFFF"
//               and raise ovf. Outputs only change on completion.
// Ports       : sys_clk   - system clock
//               sys_rst_n - asynchronous active-low reset
//               start     - conversion request, honoured only when idle
//               bin       - unsigned value, sampled when start is accepted
//               busy      - conversion in progress
//               done      - one-cycle pulse when data0..data3/ovf update
//               ovf       - last accepted value exceeded MAX_DEC
//               data0..3  - packed BCD pairs, data0[3:0] = units digit
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W   = 27,
    parameter int MAX_DEC = c_max_dec
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [7:0]       data0,
    output logic [7:0]       data1,
    output logic [7:0]       data2,
    output logic [7:0]       data3
);

    localparam int                 c_cnt_w   = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIN_W - 1);
    localparam logic [31:0]        c_max_ext = 32'(MAX_DEC);

    logic [c_state_w-1:0] r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [BIN_W-1:0]     r_shift;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_ovf;

    logic [c_bcd_w-1:0]   w_bcd_adj;
    logic [31:0]          w_bin_ext;

    assign w_bin_ext = 32'(bin);

    // One correction cell per decimal digit, applied before every shift.
    for (genvar g = 0; g < c_bcd_digits; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            data0   <= 8'h00;
            data1   <= 8'h00;
            data2   <= 8'h00;
            data3   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // Blocking on done keeps the first accept slot at the
                    // cycle after the done pulse has dropped.
                    if (start && !done) begin
                        r_shift <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        if (w_bin_ext > c_max_ext) begin
                            r_ovf   <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_ovf   <= 1'b0;
                            r_state <= c_st_conv;
                        end
                    end
                end
                c_st_conv: begin
                    // Shifting the concatenation drops the BCD MSB, which
                    // can only be set for values above MAX_DEC.
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (r_ovf) begin
                        {data3, data2, data1, data0} <= {(c_bcd_digits/2){c_ovf_pattern}};
                    end else begin
                        {data3, data2, data1, data0} <= r_bcd;
                    end
                    ovf     <= r_ovf;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : bin2bcd_seq
`default_nettype wire
